// File: rtl/tile_dim_router_if.sv
// tile_dim_router_if
//   Bundles every link of one mesh axis hop: the LO/HI input links, the LO/HI
//   output links, the local inject port, the local eject port and the
//   almost-full flags. A flit is {tgt[4:0], payload[DW-1:0]}.
//   modport slave  : the router side (consumes inputs, drives outputs)
//   modport master : the environment side (neighbours and local tile)
interface tile_dim_router_if #(
  parameter int DW = 64
) ();
  localparam int FW = DW + 5;

  logic          lo_in_valid;
  logic          lo_in_ready;
  logic [FW-1:0] lo_in_flit;
  logic          hi_in_valid;
  logic          hi_in_ready;
  logic [FW-1:0] hi_in_flit;
  logic          lo_out_valid;
  logic          lo_out_ready;
  logic [FW-1:0] lo_out_flit;
  logic          hi_out_valid;
  logic          hi_out_ready;
  logic [FW-1:0] hi_out_flit;
  logic          inj_valid;
  logic          inj_ready;
  logic [4:0]    inj_tgt;
  logic [DW-1:0] inj_data;
  logic          ej_valid;
  logic          ej_ready;
  logic [DW-1:0] ej_data;
  logic [1:0]    ej_src;
  logic [1:0]    almost_full;

  modport slave (
    input  lo_in_valid, lo_in_flit, hi_in_valid, hi_in_flit,
    input  lo_out_ready, hi_out_ready, inj_valid, inj_tgt, inj_data, ej_ready,
    output lo_in_ready, hi_in_ready, lo_out_valid, lo_out_flit,
    output hi_out_valid, hi_out_flit, inj_ready, ej_valid, ej_data, ej_src,
    output almost_full
  );

  modport master (
    output lo_in_valid, lo_in_flit, hi_in_valid, hi_in_flit,
    output lo_out_ready, hi_out_ready, inj_valid, inj_tgt, inj_data, ej_ready,
    input  lo_in_ready, hi_in_ready, lo_out_valid, lo_out_flit,
    input  hi_out_valid, hi_out_flit, inj_ready, ej_valid, ej_data, ej_src,
    input  almost_full
  );
endinterface

// File: rtl/tile_dim_router.sv
// tile_dim_router
//   One-axis mesh hop for a tile. Each input link (LO, HI) has a DEPTH-entry
//   buffer; its head either ejects to the local tile (tgt == TILE_COORD) or
//   passes straight through to the opposite output. The local inject port is
//   routed by comparing its target with TILE_COORD. Each output (lo_out,
//   hi_out, ej) is a single register slot fed by a round-robin arbiter.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : tile_dim_router_if.slave carrying all links (see interface file)
// Internal index convention: 0 = LO side, 1 = HI side. Input buffer i
// forwards to output (1-i); output d is fed by buffer (1-d).
module tile_dim_router #(
  parameter int TILE_COORD = 0,
  parameter int DW         = 64,
  parameter int DEPTH      = 8,
  parameter int AF_LVL     = 6
) (
  input logic              clk,
  input logic              rst,
  tile_dim_router_if.slave bus
);
  localparam int FW = DW + 5;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0]    TC_C    = 5'(TILE_COORD);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);

  // Three-way round-robin pick: ptr names the source with top priority.
  function automatic logic [2:0] rr_pick3(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] gnt;
    case (ptr)
      2'd1:    gnt = req[1] ? 3'b010 : (req[2] ? 3'b100 : (req[0] ? 3'b001 : 3'b000));
      2'd2:    gnt = req[2] ? 3'b100 : (req[0] ? 3'b001 : (req[1] ? 3'b010 : 3'b000));
      default: gnt = req[0] ? 3'b001 : (req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000));
    endcase
    return gnt;
  endfunction

  // Input-buffer state
  logic [FW-1:0] mem_r     [2][DEPTH];
  logic [AW-1:0] wr_ptr_r  [2];
  logic [AW-1:0] rd_ptr_r  [2];
  logic [CW-1:0] cnt_r     [2];
  logic [CW-1:0] cnt_nxt_s [2];
  logic [FW-1:0] in_flit_s [2];
  logic [FW-1:0] head_s    [2];
  logic [1:0]    in_valid_s, in_rdy_r, af_r, push_s, pop_s;
  logic [1:0]    head_vld_s, head_ej_s;

  // Output-stage state
  logic [1:0]    out_vld_r, out_rdy_s, out_free_s, rr_r;
  logic [FW-1:0] out_flit_r [2];
  logic [1:0]    breq_s, ireq_s, gnt_b_s, gnt_i_s;
  logic          ej_vld_r, ej_free_s;
  logic [DW-1:0] ej_data_r;
  logic [1:0]    ej_src_r, ej_rr_r, ej_sel_s;
  logic [2:0]    ej_req_s, ej_gnt_s;
  logic [FW-1:0] inj_flit_s;

  assign in_valid_s   = {bus.hi_in_valid, bus.lo_in_valid};
  assign in_flit_s[0] = bus.lo_in_flit;
  assign in_flit_s[1] = bus.hi_in_flit;
  assign out_rdy_s    = {bus.hi_out_ready, bus.lo_out_ready};
  assign inj_flit_s   = {bus.inj_tgt, bus.inj_data};

  // Buffer heads, routing decisions and occupancy bookkeeping
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_s[i]     = mem_r[i][rd_ptr_r[i]];
      head_vld_s[i] = (cnt_r[i] != '0);
      head_ej_s[i]  = (head_s[i][FW-1:DW] == TC_C);
      push_s[i]     = in_valid_s[i] & in_rdy_r[i];
      pop_s[i]      = gnt_b_s[1-i] | ej_gnt_s[i];
      cnt_nxt_s[i]  = cnt_r[i] + {{AW{1'b0}}, push_s[i]} - {{AW{1'b0}}, pop_s[i]};
    end
  end

  // Link-output arbitration: through-buffer head vs. inject, RR bit breaks ties
  always_comb begin
    ireq_s[0] = bus.inj_valid & (bus.inj_tgt < TC_C);
    ireq_s[1] = bus.inj_valid & (bus.inj_tgt > TC_C);
    for (int d = 0; d < 2; d++) begin
      out_free_s[d] = ~out_vld_r[d] | out_rdy_s[d];
      breq_s[d]     = head_vld_s[1-d] & ~head_ej_s[1-d];
      gnt_b_s[d]    = 1'b0;
      gnt_i_s[d]    = 1'b0;
      if (out_free_s[d]) begin
        if (breq_s[d] && ireq_s[d]) begin
          gnt_i_s[d] = rr_r[d];
          gnt_b_s[d] = ~rr_r[d];
        end else begin
          gnt_b_s[d] = breq_s[d];
          gnt_i_s[d] = ireq_s[d];
        end
      end else begin
        gnt_b_s[d] = 1'b0;
      end
    end
  end

  // Eject arbitration across LO head, HI head and inject loopback
  always_comb begin
    ej_free_s = ~ej_vld_r | bus.ej_ready;
    ej_req_s  = {bus.inj_valid & (bus.inj_tgt == TC_C),
                 head_vld_s[1] & head_ej_s[1],
                 head_vld_s[0] & head_ej_s[0]};
    if (ej_free_s) begin
      ej_gnt_s = rr_pick3(ej_req_s, ej_rr_r);
    end else begin
      ej_gnt_s = 3'b000;
    end
    if (ej_gnt_s[1]) begin
      ej_sel_s = 2'd1;
    end else if (ej_gnt_s[2]) begin
      ej_sel_s = 2'd2;
    end else begin
      ej_sel_s = 2'd0;
    end
  end

  // Buffer storage; contents need no reset because count gates the head
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) mem_r[i][wr_ptr_r[i]] <= in_flit_s[i];
    end
  end

  // Buffer pointers, occupancy and registered ready/almost-full flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        cnt_r[i]    <= '0;
      end
      in_rdy_r <= 2'b11;
      af_r     <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        cnt_r[i]    <= cnt_nxt_s[i];
        in_rdy_r[i] <= (cnt_nxt_s[i] < DEPTH_C);
        af_r[i]     <= (cnt_nxt_s[i] >= AF_C);
      end
    end
  end

  // Link output registers and their RR bits (flip to the loser when contested)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_r     <= 2'b00;
      rr_r          <= 2'b00;
      out_flit_r[0] <= '0;
      out_flit_r[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (gnt_b_s[d]) begin
          out_vld_r[d]  <= 1'b1;
          out_flit_r[d] <= head_s[1-d];
        end else if (gnt_i_s[d]) begin
          out_vld_r[d]  <= 1'b1;
          out_flit_r[d] <= inj_flit_s;
        end else if (out_rdy_s[d]) begin
          out_vld_r[d]  <= 1'b0;
        end
        if (gnt_b_s[d] && ireq_s[d]) begin
          rr_r[d] <= 1'b1;
        end else if (gnt_i_s[d] && breq_s[d]) begin
          rr_r[d] <= 1'b0;
        end
      end
    end
  end

  // Eject register; the granted source drops to lowest priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ej_vld_r  <= 1'b0;
      ej_data_r <= '0;
      ej_src_r  <= 2'd0;
      ej_rr_r   <= 2'd0;
    end else if (|ej_gnt_s) begin
      ej_vld_r <= 1'b1;
      ej_src_r <= ej_sel_s;
      ej_rr_r  <= (ej_sel_s == 2'd2) ? 2'd0 : ej_sel_s + 2'd1;
      case (ej_sel_s)
        2'd0:    ej_data_r <= head_s[0][DW-1:0];
        2'd1:    ej_data_r <= head_s[1][DW-1:0];
        default: ej_data_r <= bus.inj_data;
      endcase
    end else if (bus.ej_ready) begin
      ej_vld_r <= 1'b0;
    end
  end

  assign bus.lo_in_ready  = in_rdy_r[0];
  assign bus.hi_in_ready  = in_rdy_r[1];
  assign bus.almost_full  = af_r;
  assign bus.lo_out_valid = out_vld_r[0];
  assign bus.lo_out_flit  = out_flit_r[0];
  assign bus.hi_out_valid = out_vld_r[1];
  assign bus.hi_out_flit  = out_flit_r[1];
  assign bus.inj_ready    = gnt_i_s[0] | gnt_i_s[1] | ej_gnt_s[2];
  assign bus.ej_valid     = ej_vld_r;
  assign bus.ej_data      = ej_data_r;
  assign bus.ej_src       = ej_src_r;
endmodule
